// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state, opcodes, datapath select fields, strobe bundle.
// Pure types and constants; no timing or flow control of its own.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ORIEX  = 4'd8,
    S_ORIWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_ORI = 6'h0D;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_OR = 2'b11} alu_op_t;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BROFF = 2'b11} srcb_t;
  typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pcsrc_t;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_TIMEOUT = 2'b10} err_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    branch_not;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    srcb_t   alu_src_b;
    logic    ext_zero;
    alu_op_t alu_op;
    pcsrc_t  pc_source;
    logic    status_write;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory-wait cycles; timeout fires combinationally on the MEM_TIMEOUT-th wait.
// Clear has priority over counting; no flow control of its own.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wait_en,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wait_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the waits already taken, so this cycle is wait number cnt+1
  assign timeout = wait_en && (cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: 3-5 cycles per instruction at zero wait, strobes decoded from state.
// Stalls in FETCH/MEMRD/MEMWR on mem_ready; traps to HALT on illegal opcode or wait timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_not,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_zero,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic                 status_write,
  output logic                 halted,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t               state, state_nxt;
  err_t                 err_q;
  logic [CNT_WIDTH-1:0] retired_q;
  ctrl_t                ctrl;
  logic                 wait_en, timeout, retire, illegal;

  assign wait_en = !mem_ready &&
                   (((state == S_FETCH) && run) || (state == S_MEMRD) || (state == S_MEMWR));
  assign illegal = (state == S_DECODE) && !is_legal(opcode);
  assign retire  = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ORIWB) ||
                   (state == S_BRANCH) || (state == S_JUMP) || ((state == S_MEMWR) && mem_ready);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_nxt != state),
    .wait_en (wait_en),
    .timeout (timeout)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH:  if (run && mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:           state_nxt = S_EXEC;
          OP_LW, OP_SW:   state_nxt = S_MEMADR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          OP_ORI:         state_nxt = S_ORIEX;
          default:        state_nxt = S_HALT;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ORIEX:  state_nxt = S_ORIWB;
      S_MEMWB, S_ALUWB, S_ORIWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
    if (timeout) state_nxt = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      err_q     <= ERR_NONE;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
      if (err_q == ERR_NONE) begin
        if (illegal)      err_q <= ERR_ILLEGAL;
        else if (timeout) err_q <= ERR_TIMEOUT;
      end
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        if (run) begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
      end
      S_DECODE: ctrl.alu_src_b = SRCB_BROFF;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write    = 1'b1;
        ctrl.reg_dst      = 1'b1;
        ctrl.status_write = 1'b1;
      end
      S_ORIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_zero  = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      S_ORIWB: begin
        ctrl.reg_write    = 1'b1;
        ctrl.status_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_not    = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
    // reset is combinationally gated so nothing leaks while rst_n is low
    if (timeout || !rst_n) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_not    = ctrl.branch_not;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign ext_zero      = ctrl.ext_zero;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign status_write  = ctrl.status_write;
  assign halted        = rst_n && (state == S_HALT);
  assign err_code      = err_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected strobes and retire counts are queued
// as each cycle's stimulus is driven and popped for comparison mid-cycle.
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, run, mem_ready;
  logic [5:0]    opcode;
  logic          pc_write, pc_write_cond, branch_not, iord, mem_read, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, status_write, halted;
  logic [1:0]    alu_src_b, alu_op, pc_source, err_code;
  logic [CW-1:0] retired;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_not, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op, pc_source;
    logic       status_write, halted;
    logic [1:0] err_code;
  } obs_t;

  typedef enum {K_ZERO, K_FETCH, K_DEC, K_MA, K_MR, K_MWB, K_MW, K_EX, K_AWB, K_OX, K_OWB,
                K_BR, K_J, K_HALT_ILL, K_HALT_TO} kind_e;

  obs_t          obs;
  obs_t          exp_q[$];
  logic [CW-1:0] ret_q[$];
  string         tag_q[$];
  logic [CW-1:0] exp_retired;
  int            n_pass = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_not(branch_not),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op),
    .pc_source(pc_source), .status_write(status_write), .halted(halted),
    .err_code(err_code), .retired(retired)
  );

  assign obs = {pc_write, pc_write_cond, branch_not, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op,
                pc_source, status_write, halted, err_code};

  function automatic obs_t ex(input kind_e k, input logic x);
    obs_t o = '0;
    case (k)
      K_FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = x; o.pc_write = x; end
      K_DEC:      o.alu_src_b = 2'b11;
      K_MA:       begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      K_MR:       begin o.mem_read = 1; o.iord = 1; end
      K_MWB:      begin o.reg_write = 1; o.mem_to_reg = 1; end
      K_MW:       begin o.mem_write = 1; o.iord = 1; end
      K_EX:       begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      K_AWB:      begin o.reg_write = 1; o.reg_dst = 1; o.status_write = 1; end
      K_OX:       begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.ext_zero = 1; o.alu_op = 2'b11; end
      K_OWB:      begin o.reg_write = 1; o.status_write = 1; end
      K_BR:       begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                        o.pc_source = 2'b01; o.branch_not = x; end
      K_J:        begin o.pc_write = 1; o.pc_source = 2'b10; end
      K_HALT_ILL: begin o.halted = 1; o.err_code = 2'b01; end
      K_HALT_TO:  begin o.halted = 1; o.err_code = 2'b10; end
      default:    ;
    endcase
    return o;
  endfunction

  task automatic compare_front();
    obs_t          e = exp_q.pop_front();
    logic [CW-1:0] r = ret_q.pop_front();
    string         t = tag_q.pop_front();
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: strobes observed %h expected %h", t, obs, e);
    n_total++;
    assert (retired === r) n_pass++;
    else $error("FAIL %s.retired: observed %0d expected %0d", t, retired, r);
  endtask

  // Called at posedge+1: drive one cycle, check mid-cycle, advance to the next posedge+1.
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input obs_t e, input string tag, input bit retires);
    run = r; opcode = op; mem_ready = rdy;
    exp_q.push_back(e); ret_q.push_back(exp_retired); tag_q.push_back(tag);
    @(negedge clk);
    compare_front();
    @(posedge clk); #1;
    if (retires) exp_retired = exp_retired + 1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
    exp_retired = '0;
    #1;
    exp_q.push_back('0); ret_q.push_back('0); tag_q.push_back(tag);
    compare_front();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 6'h00; exp_retired = '0;
    #2;
    reset_pulse("reset");

    // R-type, zero wait; run dropped mid-instruction must not matter
    step(1, 6'h00, 1, ex(K_FETCH, 1), "r.fetch", 0);
    step(0, 6'h00, 1, ex(K_DEC, 0),   "r.decode", 0);
    step(0, 6'h00, 1, ex(K_EX, 0),    "r.exec", 0);
    step(0, 6'h00, 1, ex(K_AWB, 0),   "r.aluwb", 1);
    step(0, 6'h00, 1, ex(K_ZERO, 0),  "idle.run0", 0);
    step(0, 6'h00, 0, ex(K_ZERO, 0),  "idle.run0b", 0);

    // LW with three wait cycles in MEMRD; ready lands on the timeout-boundary cycle
    step(1, 6'h23, 1, ex(K_FETCH, 1), "lw.fetch", 0);
    step(1, 6'h23, 1, ex(K_DEC, 0),   "lw.decode", 0);
    step(1, 6'h23, 1, ex(K_MA, 0),    "lw.memadr", 0);
    for (int i = 0; i < 3; i++) step(1, 6'h23, 0, ex(K_MR, 0), "lw.memrd_wait", 0);
    step(1, 6'h23, 1, ex(K_MR, 0),    "lw.memrd_done", 0);
    step(1, 6'h23, 0, ex(K_MWB, 0),   "lw.memwb", 1);

    // BNE then BEQ
    step(1, 6'h05, 1, ex(K_FETCH, 1), "bne.fetch", 0);
    step(1, 6'h05, 0, ex(K_DEC, 0),   "bne.decode", 0);
    step(1, 6'h05, 0, ex(K_BR, 1),    "bne.branch", 1);
    step(1, 6'h04, 1, ex(K_FETCH, 1), "beq.fetch", 0);
    step(1, 6'h04, 1, ex(K_DEC, 0),   "beq.decode", 0);
    step(1, 6'h04, 1, ex(K_BR, 0),    "beq.branch", 1);

    // J, ORI, SW with one write wait
    step(1, 6'h02, 1, ex(K_FETCH, 1), "j.fetch", 0);
    step(1, 6'h02, 1, ex(K_DEC, 0),   "j.decode", 0);
    step(1, 6'h02, 1, ex(K_J, 0),     "j.jump", 1);
    step(1, 6'h0D, 1, ex(K_FETCH, 1), "ori.fetch", 0);
    step(1, 6'h0D, 1, ex(K_DEC, 0),   "ori.decode", 0);
    step(1, 6'h0D, 1, ex(K_OX, 0),    "ori.oriex", 0);
    step(1, 6'h0D, 1, ex(K_OWB, 0),   "ori.oriwb", 1);
    step(1, 6'h2B, 1, ex(K_FETCH, 1), "sw.fetch", 0);
    step(1, 6'h2B, 1, ex(K_DEC, 0),   "sw.decode", 0);
    step(1, 6'h2B, 1, ex(K_MA, 0),    "sw.memadr", 0);
    step(1, 6'h2B, 0, ex(K_MW, 0),    "sw.memwr_wait", 0);
    step(1, 6'h2B, 1, ex(K_MW, 0),    "sw.memwr_done", 1);

    // Fetch wait where ready arrives exactly on the would-be timeout cycle
    for (int i = 0; i < TO - 1; i++) step(1, 6'h02, 0, ex(K_FETCH, 0), "fetch.wait", 0);
    step(1, 6'h02, 1, ex(K_FETCH, 1), "fetch.ready_at_limit", 0);
    step(1, 6'h02, 1, ex(K_DEC, 0),   "j2.decode", 0);
    step(1, 6'h02, 1, ex(K_J, 0),     "j2.jump", 1);

    // Reset in the middle of an R-type
    step(1, 6'h00, 1, ex(K_FETCH, 1), "abort.fetch", 0);
    step(1, 6'h00, 1, ex(K_DEC, 0),   "abort.decode", 0);
    reset_pulse("abort.reset");
    step(1, 6'h00, 1, ex(K_FETCH, 1), "abort.refetch", 0);

    // Illegal opcode traps and stays put
    step(1, 6'h3F, 1, ex(K_DEC, 0),   "ill.decode", 0);
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)),
           ex(K_HALT_ILL, 0), "ill.halt", 0);
    reset_pulse("ill.reset");

    // Fetch timeout: last wait cycle issues nothing, then HALT with err 10
    for (int i = 0; i < TO - 1; i++) step(1, 6'h00, 0, ex(K_FETCH, 0), "to.wait", 0);
    step(1, 6'h00, 0, ex(K_ZERO, 0),    "to.trap_cycle", 0);
    for (int i = 0; i < 3; i++) step(1, 6'h00, 1, ex(K_HALT_TO, 0), "to.halt", 0);
    reset_pulse("to.reset");
    step(1, 6'h02, 1, ex(K_FETCH, 1), "rec.fetch", 0);
    step(1, 6'h02, 1, ex(K_DEC, 0),   "rec.decode", 0);
    step(1, 6'h02, 1, ex(K_J, 0),     "rec.jump", 1);
    step(0, 6'h02, 1, ex(K_ZERO, 0),  "rec.idle", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
